// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised oversampling UART receiver, optional break detect via BREAK_DETECT_EN
module uart_rx_cfg #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic                  Stop_Bits,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_Err,
`ifdef BREAK_DETECT_EN
    output logic                  STP_Err,
    output logic                  Brk_Det
`else
    output logic                  STP_Err
`endif
);

    localparam int                    BC_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BC_W-1:0]       BC_LAST = BC_W'(DATA_WIDTH - 1);
    localparam logic [BC_W-1:0]       BC_ONE  = BC_W'(1);
    localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);

`ifdef BREAK_DETECT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
    } state_t;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q, state_d;
    logic [PRESCALE_W-1:0]  pre_q, edge_cnt, half;
    logic [BC_W-1:0]        bit_cnt;
    logic                   par_en_q, par_typ_q, stop2_q;
    logic [2:0]             smp_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                   bit_val, bit_end, exp_par, enter_done;
    logic                   frame_ok, frame_brk;
`ifdef BREAK_DETECT_EN
    logic                   zero_q, zero_d, brk_q, brk_d;
`endif

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign half       = pre_q >> 1;
    assign bit_end    = (edge_cnt == pre_q - ONE);
    assign bit_val    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign exp_par    = par_typ_q ? ~(^shift_q) : ^shift_q;
    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
`ifdef BREAK_DETECT_EN
    assign frame_brk  = brk_d;
`else
    assign frame_brk  = 1'b0;
`endif
    assign frame_ok   = ~par_err_d & ~stp_err_d & ~frame_brk;

    // Idle-high synchroniser: reset to 1 so the line never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Error/break flags are resolved here so the DONE outputs include the final stop bit
    always_comb begin
        state_d   = state_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
`ifdef BREAK_DETECT_EN
        zero_d    = zero_q;
        brk_d     = brk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
`ifdef BREAK_DETECT_EN
                    zero_d    = 1'b1;
                    brk_d     = 1'b0;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
`ifdef BREAK_DETECT_EN
                    zero_d = zero_q & ~bit_val;
`endif
                    if (bit_cnt == BC_LAST) state_d = par_en_q ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = bit_val ^ exp_par;
`ifdef BREAK_DETECT_EN
                    zero_d    = zero_q & ~bit_val;
`endif
                    state_d   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    stp_err_d = ~bit_val;
`ifdef BREAK_DETECT_EN
                    brk_d     = zero_q & ~bit_val;
`endif
                    state_d   = stop2_q ? S_STOP2 : S_DONE;
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    stp_err_d = stp_err_q | ~bit_val;
                    state_d   = S_DONE;
                end
            end
`ifdef BREAK_DETECT_EN
            S_DONE:  state_d = brk_q ? S_BREAK : S_IDLE;
            S_BREAK: begin
                if (rx_s && bit_end) state_d = S_IDLE;
            end
`else
            S_DONE:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            pre_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
`ifdef BREAK_DETECT_EN
            zero_q    <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
`ifdef BREAK_DETECT_EN
            zero_q    <= zero_d;
            brk_q     <= brk_d;
`endif
            case (state_q)
                S_IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        pre_q     <= Prescale;
                        par_en_q  <= Par_En;
                        par_typ_q <= Par_Typ;
                        stop2_q   <= Stop_Bits;
                    end
                end
                S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
                    edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
                    if (edge_cnt == half - ONE) smp_q[0] <= rx_s;
                    if (edge_cnt == half)       smp_q[1] <= rx_s;
                    if (edge_cnt == half + ONE) smp_q[2] <= rx_s;
                    if (state_q == S_DATA && bit_end) begin
                        shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BC_ONE;
                    end
                end
`ifdef BREAK_DETECT_EN
                // Counts consecutive high cycles; any low restarts the wait
                S_BREAK: edge_cnt <= rx_s ? edge_cnt + ONE : '0;
`endif
                default: edge_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            PAR_Err    <= 1'b0;
            STP_Err    <= 1'b0;
`ifdef BREAK_DETECT_EN
            Brk_Det    <= 1'b0;
`endif
        end else begin
            Data_Valid <= enter_done & frame_ok;
            PAR_Err    <= enter_done & par_err_d & ~frame_brk;
            STP_Err    <= enter_done & stp_err_d & ~frame_brk;
`ifdef BREAK_DETECT_EN
            Brk_Det    <= enter_done & frame_brk;
`endif
            if (enter_done && frame_ok) P_DATA <= shift_q;
        end
    end

endmodule
